// File: rtl/iter_shift_unit_if.sv
// rtl/iter_shift_unit_if.sv - request/result bundle between the control FSM and the iterative shifter
interface iter_shift_unit_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               Start;
  logic               Flush;
  logic [1:0]         Mode;
  logic [WIDTH-1:0]   Operand;
  logic [SHAMT_W-1:0] Shamt;
  logic               OvIn;
  logic               Busy;
  logic               Done;
  logic [WIDTH-1:0]   Result;
  logic [WIDTH-1:0]   ShiftOut;
  logic               OvOut;

  modport master (
    output Start, Flush, Mode, Operand, Shamt, OvIn,
    input  Busy, Done, Result, ShiftOut, OvOut
  );

  modport slave (
    input  Start, Flush, Mode, Operand, Shamt, OvIn,
    output Busy, Done, Result, ShiftOut, OvOut
  );
endinterface

// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - one-bit-per-cycle shifter with overflow fill/capture for chained shifts
module iter_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic             CLK,
  input  logic             RST_n,
  iter_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_SLL = 2'b00,
    M_SRL = 2'b01,
    M_SRA = 2'b10,
    M_ROL = 2'b11
  } mode_t;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic               ovin_q, ovin_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   shout_q, shout_d;
  logic               ovout_q, ovout_d;

  logic right_shift;
  logic out_bit;

  assign right_shift = (mode_q == M_SRL) || (mode_q == M_SRA);
  assign out_bit     = right_shift ? result_q[0] : result_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ovin_d   = ovin_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    shout_d  = shout_q;
    ovout_d  = ovout_q;

    // Flush leaves the datapath untouched so partial results stay visible.
    if (bus.Flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            result_d = bus.Operand;
            mode_d   = mode_t'(bus.Mode);
            ovin_d   = bus.OvIn;
            cnt_d    = bus.Shamt;
            shout_d  = '0;
            ovout_d  = 1'b0;
            state_d  = (bus.Shamt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          case (mode_q)
            M_SLL:   result_d = {result_q[WIDTH-2:0], ovin_q};
            M_SRL:   result_d = {ovin_q, result_q[WIDTH-1:1]};
            M_SRA:   result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
          endcase
          shout_d = right_shift ? {out_bit, shout_q[WIDTH-1:1]}
                                : {shout_q[WIDTH-2:0], out_bit};
          ovout_d = out_bit;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= M_SLL;
      ovin_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      shout_q  <= '0;
      ovout_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ovin_q   <= ovin_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      shout_q  <= shout_d;
      ovout_q  <= ovout_d;
    end
  end

  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.Done     = (state_q == ST_DONE);
  assign bus.Result   = result_q;
  assign bus.ShiftOut = shout_q;
  assign bus.OvOut    = ovout_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb/tb_iter_shift_unit.sv - vector table plus hand-built corner sequences for iter_shift_unit
module tb_iter_shift_unit;

  logic clk;
  logic rst_n;

  iter_shift_unit_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  iter_shift_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] op;
    logic [2:0] sh;
    logic       ovin;
    logic [7:0] res;
    logic [7:0] so;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [7:0] so;
    logic       ov;
    int         lat;
  } exp_t;

  int   checks;
  int   failures;
  vec_t vecs[10];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    exp_t got;
    bit   found;
    e.res = v.res;
    e.so  = v.so;
    e.ov  = v.ov;
    e.lat = int'(v.sh) + 1;
    got   = e;
    sb.push_back(e);
    bus.Start   = 1'b1;
    bus.Mode    = v.mode;
    bus.Operand = v.op;
    bus.Shamt   = v.sh;
    bus.OvIn    = v.ovin;
    tick();
    bus.Start   = 1'b0;
    bus.Mode    = 2'($urandom);
    bus.Operand = 8'($urandom);
    bus.Shamt   = 3'($urandom);
    bus.OvIn    = 1'($urandom);
    found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      chk("busy_during_op", 32'(bus.Busy), 32'd1);
      if (bus.Done) begin
        found = 1'b1;
        got = sb.pop_front();
        chk("result",   32'(bus.Result),   32'(got.res));
        chk("shiftout", 32'(bus.ShiftOut), 32'(got.so));
        chk("ovout",    32'(bus.OvOut),    32'(got.ov));
        chk("latency",  32'(c),            32'(got.lat));
      end else begin
        tick();
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no Done expected Done by cycle %0d", e.lat);
      sb.delete();
    end
    tick();
    chk("busy_after_done", 32'(bus.Busy),   32'd0);
    chk("done_one_cycle",  32'(bus.Done),   32'd0);
    chk("result_hold",     32'(bus.Result), 32'(got.res));
  endtask

  task automatic start_sll_ff7();
    bus.Start   = 1'b1;
    bus.Mode    = 2'b00;
    bus.Operand = 8'hFF;
    bus.Shamt   = 3'd7;
    bus.OvIn    = 1'b0;
    tick();
    bus.Start   = 1'b0;
  endtask

  initial begin
    int done_seen;
    checks   = 0;
    failures = 0;

    //        mode   op     sh    ovin  res    so     ov
    vecs[0] = '{2'b00, 8'h96, 3'd3, 1'b0, 8'hB0, 8'h04, 1'b0};
    vecs[1] = '{2'b10, 8'h81, 3'd2, 1'b1, 8'hE0, 8'h40, 1'b0};
    vecs[2] = '{2'b01, 8'h01, 3'd1, 1'b1, 8'h80, 8'h80, 1'b1};
    vecs[3] = '{2'b11, 8'h81, 3'd7, 1'b0, 8'hC0, 8'h40, 1'b0};
    vecs[4] = '{2'b11, 8'h5A, 3'd0, 1'b1, 8'h5A, 8'h00, 1'b0};
    vecs[5] = '{2'b00, 8'h01, 3'd7, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[6] = '{2'b01, 8'hA5, 3'd4, 1'b0, 8'h0A, 8'h50, 1'b0};
    vecs[7] = '{2'b10, 8'h80, 3'd7, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[8] = '{2'b01, 8'h80, 3'd7, 1'b0, 8'h01, 8'h00, 1'b0};
    vecs[9] = '{2'b00, 8'hC3, 3'd2, 1'b1, 8'h0F, 8'h03, 1'b1};

    rst_n       = 1'b0;
    bus.Start   = 1'b0;
    bus.Flush   = 1'b0;
    bus.Mode    = 2'b00;
    bus.Operand = 8'h00;
    bus.Shamt   = 3'd0;
    bus.OvIn    = 1'b0;
    #12;
    chk("rst_busy",     32'(bus.Busy),     32'd0);
    chk("rst_done",     32'(bus.Done),     32'd0);
    chk("rst_result",   32'(bus.Result),   32'd0);
    chk("rst_shiftout", 32'(bus.ShiftOut), 32'd0);
    chk("rst_ovout",    32'(bus.OvOut),    32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i]);
    end

    // Start while busy, in the Done cycle, and one cycle after Done
    start_sll_ff7();
    tick();
    tick();
    bus.Start   = 1'b1;
    bus.Operand = 8'h00;
    tick();
    bus.Start   = 1'b0;
    chk("busy_ignore_busy", 32'(bus.Busy), 32'd1);
    tick(); tick(); tick(); tick();
    chk("ff7_done",     32'(bus.Done),     32'd1);
    chk("ff7_result",   32'(bus.Result),   32'h80);
    chk("ff7_shiftout", 32'(bus.ShiftOut), 32'h7F);
    chk("ff7_ovout",    32'(bus.OvOut),    32'd1);
    bus.Start   = 1'b1;
    bus.Mode    = 2'b00;
    bus.Operand = 8'h01;
    bus.Shamt   = 3'd1;
    bus.OvIn    = 1'b0;
    tick();
    chk("done_start_ign_busy", 32'(bus.Busy),   32'd0);
    chk("done_start_ign_res",  32'(bus.Result), 32'h80);
    tick();
    bus.Start = 1'b0;
    chk("late_start_busy", 32'(bus.Busy), 32'd1);
    chk("late_start_done", 32'(bus.Done), 32'd0);
    tick();
    chk("late_done",   32'(bus.Done),   32'd1);
    chk("late_result", 32'(bus.Result), 32'h02);
    tick();
    chk("late_idle", 32'(bus.Busy), 32'd0);

    // Asynchronous reset in the middle of a shift
    start_sll_ff7();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy",     32'(bus.Busy),     32'd0);
    chk("arst_done",     32'(bus.Done),     32'd0);
    chk("arst_result",   32'(bus.Result),   32'd0);
    chk("arst_shiftout", 32'(bus.ShiftOut), 32'd0);
    chk("arst_ovout",    32'(bus.OvOut),    32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_idle", 32'(bus.Busy), 32'd0);

    // Flush in cycle 3 (Start also high, Flush wins)
    start_sll_ff7();
    tick();
    tick();
    bus.Flush = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    chk("flush_busy",     32'(bus.Busy),     32'd0);
    chk("flush_done",     32'(bus.Done),     32'd0);
    chk("flush_result",   32'(bus.Result),   32'hFC);
    chk("flush_shiftout", 32'(bus.ShiftOut), 32'h03);
    chk("flush_ovout",    32'(bus.OvOut),    32'd1);
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.Done) done_seen++;
      tick();
    end
    chk("flush_no_done", 32'(done_seen), 32'd0);

    // Flush beats Start in IDLE
    bus.Flush   = 1'b1;
    bus.Start   = 1'b1;
    bus.Operand = 8'h11;
    tick();
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    chk("flush_prio_busy",   32'(bus.Busy),   32'd0);
    chk("flush_prio_result", 32'(bus.Result), 32'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
